// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port on-chip RAM between two
// Avalon-MM masters, one transfer per cycle, fixed 1-cycle read return.
`timescale 1ns/1ps
module onchip_mem_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 15,
  parameter int DEPTH    = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [16:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [16:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [16:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [31:0] DEPTH_U = DEPTH;

  logic          req0, req1;
  logic          gnt0, gnt1, any_gnt;
  logic          force1;
  logic          last_gnt;
  logic [WW-1:0] wait_cnt;
  logic          rd_pend, rd_owner, rd_oor;
  logic [16:0]   sel_addr;
  logic [3:0]    sel_be;
  logic [31:0]   sel_wd;
  logic          sel_wr, sel_oor;
  logic [31:0]   rdata;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign force1 = (wait_cnt == WMAX);

  // m1 only ever wins what m0 leaves, so the grants stay one-hot
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (ARB_MODE == 0)
        gnt0 = req0 & (~req1 | last_gnt);
      else
        gnt0 = req0 & ~(req1 & force1);
      gnt1 = req1 & ~gnt0;
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign sel_addr = gnt1 ? m1_address : m0_address;
  assign sel_be   = gnt1 ? m1_byteenable : m0_byteenable;
  assign sel_wd   = gnt1 ? m1_writedata : m0_writedata;
  assign sel_wr   = gnt1 ? m1_write : m0_write;
  assign sel_oor  = {15'd0, sel_addr} >= DEPTH_U;

  assign mem_address    = reset_n ? sel_addr : '0;
  assign mem_byteenable = reset_n ? sel_be : '0;
  assign mem_writedata  = reset_n ? sel_wd : '0;
  assign mem_chipselect = any_gnt & ~sel_oor;
  assign mem_write      = any_gnt & sel_wr & ~sel_oor;
  assign mem_clken      = reset_n;

  assign m0_waitrequest = ~reset_n | (req0 & ~gnt0);
  assign m1_waitrequest = ~reset_n | (req1 & ~gnt1);

  // out-of-range reads see stale RAM output, so mask it here
  assign rdata            = (~reset_n | rd_oor) ? 32'h0 : mem_readdata;
  assign m0_readdata      = rdata;
  assign m1_readdata      = rdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend & rd_owner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= 1'b1;
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      if (any_gnt)
        last_gnt <= gnt1;
      if (req1 & ~gnt1) begin
        if (!force1)
          wait_cnt <= wait_cnt + WW'(1);
      end else begin
        wait_cnt <= '0;
      end
      rd_pend  <= any_gnt & ~sel_wr;
      rd_owner <= gnt1;
      rd_oor   <= sel_oor;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: round-robin and fixed-priority instances
// driven by one stimulus stream and checked against a transfer-level model.
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;

  localparam int DEPTH = 100000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] a0, a1;
  logic [3:0]  be0, be1;
  logic        rd0, rd1, wr0, wr1;
  logic [31:0] wd0, wd1;

  logic        wait0 [2], wait1 [2], rdv0 [2], rdv1 [2];
  logic        mcs [2], mwe [2], mck [2];
  logic [31:0] rdd0 [2], rdd1 [2], mwd [2], mrd [2];
  logic [16:0] madr [2];
  logic [3:0]  mbe [2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bit [31:0] ram [int];

    onchip_mem_arbiter #(
      .ARB_MODE(g),
      .MAX_WAIT(g == 0 ? 15 : 3),
      .DEPTH(DEPTH)
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .m0_address(a0),
      .m0_byteenable(be0),
      .m0_read(rd0),
      .m0_write(wr0),
      .m0_writedata(wd0),
      .m0_waitrequest(wait0[g]),
      .m0_readdata(rdd0[g]),
      .m0_readdatavalid(rdv0[g]),
      .m1_address(a1),
      .m1_byteenable(be1),
      .m1_read(rd1),
      .m1_write(wr1),
      .m1_writedata(wd1),
      .m1_waitrequest(wait1[g]),
      .m1_readdata(rdd1[g]),
      .m1_readdatavalid(rdv1[g]),
      .mem_address(madr[g]),
      .mem_byteenable(mbe[g]),
      .mem_chipselect(mcs[g]),
      .mem_write(mwe[g]),
      .mem_writedata(mwd[g]),
      .mem_clken(mck[g]),
      .mem_readdata(mrd[g])
    );

    // RAM with a registered read port
    always @(posedge clk) begin
      if (mck[g] && mcs[g]) begin
        if (mwe[g])
          ram[int'(madr[g])] = merge(ram.exists(int'(madr[g])) ?
                                     ram[int'(madr[g])] : 32'h0,
                                     mwd[g], mbe[g]);
        else
          mrd[g] <= ram.exists(int'(madr[g])) ? ram[int'(madr[g])] : 32'h0;
      end
    end
  end

  task automatic chk(input string nm, input int g,
                     input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, g, got, exp, $time);
    end
  endtask

  // transfer-level model
  bit [31:0] mmem [int];
  int        last [2];
  int        streak [2];
  bit        pend [2];
  int        powner [2];
  bit [31:0] pdata [2];

  function automatic bit [31:0] mget(input int key);
    return mmem.exists(key) ? mmem[key] : 32'h0;
  endfunction

  task automatic model_step(input int g);
    bit req0, req1, wr, inr;
    int w, addr, maxw, key;
    bit [3:0] be;
    bit [31:0] wd;
    maxw = (g == 0) ? 15 : 3;
    if (!reset_n) begin
      chk("rst_wait0", g, wait0[g], 1);
      chk("rst_wait1", g, wait1[g], 1);
      chk("rst_rdv0", g, rdv0[g], 0);
      chk("rst_rdv1", g, rdv1[g], 0);
      chk("rst_rdd0", g, rdd0[g], 0);
      chk("rst_rdd1", g, rdd1[g], 0);
      chk("rst_cs", g, mcs[g], 0);
      chk("rst_we", g, mwe[g], 0);
      chk("rst_clken", g, mck[g], 0);
      chk("rst_addr", g, 32'(madr[g]), 0);
      chk("rst_be", g, 32'(mbe[g]), 0);
      chk("rst_wd", g, mwd[g], 0);
      last[g] = 1;
      streak[g] = 0;
      pend[g] = 0;
      return;
    end
    req0 = rd0 | wr0;
    req1 = rd1 | wr1;
    if (req0 && req1) begin
      if (g == 0) w = (last[g] == 0) ? 1 : 0;
      else w = (streak[g] >= maxw) ? 1 : 0;
    end else if (req0) w = 0;
    else if (req1) w = 1;
    else w = -1;

    chk("rdv0", g, rdv0[g], pend[g] && powner[g] == 0);
    chk("rdv1", g, rdv1[g], pend[g] && powner[g] == 1);
    if (pend[g])
      chk("rdata", g, powner[g] == 0 ? rdd0[g] : rdd1[g], pdata[g]);
    chk("wait0", g, wait0[g], req0 && w != 0);
    chk("wait1", g, wait1[g], req1 && w != 1);
    chk("clken", g, mck[g], 1);

    pend[g] = 0;
    if (w >= 0) begin
      addr = (w == 1) ? int'(a1) : int'(a0);
      wr   = (w == 1) ? wr1 : wr0;
      be   = (w == 1) ? be1 : be0;
      wd   = (w == 1) ? wd1 : wd0;
      inr  = addr < DEPTH;
      key  = g * 262144 + addr;
      chk("cs", g, mcs[g], inr);
      chk("we", g, mwe[g], wr && inr);
      if (inr) begin
        chk("addr", g, 32'(madr[g]), addr);
        chk("be", g, 32'(mbe[g]), 32'(be));
        if (wr) chk("wdata", g, mwd[g], wd);
      end
      last[g] = w;
      if (wr) begin
        if (inr) mmem[key] = merge(mget(key), wd, be);
      end else begin
        pend[g]   = 1;
        powner[g] = w;
        pdata[g]  = inr ? mget(key) : 32'h0;
      end
    end else begin
      chk("cs_idle", g, mcs[g], 0);
      chk("we_idle", g, mwe[g], 0);
    end
    if (req1 && w != 1) streak[g] = (streak[g] < maxw) ? streak[g] + 1 : maxw;
    else streak[g] = 0;
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      #2;
      for (int g = 0; g < 2; g++) model_step(g);
    end
  end

  task automatic idle();
    rd0 = 0; wr0 = 0; a0 = '0; be0 = '0; wd0 = '0;
    rd1 = 0; wr1 = 0; a1 = '0; be1 = '0; wd1 = '0;
  endtask

  task automatic m0_op(input bit r, input bit w, input int ad,
                       input logic [3:0] b, input logic [31:0] d);
    rd0 = r; wr0 = w; a0 = 17'(ad); be0 = b; wd0 = d;
  endtask

  task automatic m1_op(input bit r, input bit w, input int ad,
                       input logic [3:0] b, input logic [31:0] d);
    rd1 = r; wr1 = w; a1 = 17'(ad); be1 = b; wd1 = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return $urandom_range(0, 15);
    case ($urandom_range(0, 3))
      0: return 99999;
      1: return 100000;
      2: return 100001;
      default: return 131071;
    endcase
  endfunction

  task automatic rand_master(input int m);
    int op, ad;
    logic [3:0] b;
    logic [31:0] d;
    op = $urandom_range(0, 3);
    ad = pick_addr();
    b  = 4'($urandom_range(0, 15));
    d  = $urandom;
    if (m == 0) m0_op(op[0], op[1], ad, b, d);
    else m1_op(op[0], op[1], ad, b, d);
  endtask

  initial begin : stim
    idle();
    reset_n = 0;
    repeat (3) tick();
    reset_n = 1;
    tick(); idle();

    // single master write then read
    tick(); idle(); m0_op(0, 1, 5, 4'hF, 32'hDEADBEEF);
    #3 chk("sm_wr_wait", 0, wait0[0], 0);
    tick(); idle(); m0_op(1, 0, 5, 4'hF, 0);
    #3 chk("sm_rd_wait", 0, wait0[0], 0);
    tick(); idle();
    #3 chk("sm_rdv", 0, rdv0[0], 1);
    chk("sm_data", 0, rdd0[0], 32'hDEADBEEF);
    chk("sm_rdv1", 0, rdv1[0], 0);

    // contention: round-robin alternates, fixed priority gives m1 1 of 4
    tick(); idle(); m0_op(0, 1, 1, 4'hF, 32'h11);
    tick(); idle(); m1_op(0, 1, 2, 4'hF, 32'h22);
    for (int k = 0; k < 8; k++) begin
      tick(); idle();
      m0_op(1, 0, 1, 4'hF, 0);
      m1_op(1, 0, 2, 4'hF, 0);
      #3;
      chk("rr_wait0", 0, wait0[0], k % 2);
      chk("rr_wait1", 0, wait1[0], 1 - k % 2);
      chk("fp_wait1", 1, wait1[1], (k % 4) != 3);
      if (k > 0) begin
        chk("rr_rdv0", 0, rdv0[0], k % 2);
        chk("rr_ret", 0, (k % 2 == 1) ? rdd0[0] : rdd1[0],
            (k % 2 == 1) ? 32'h11 : 32'h22);
      end
    end

    // out of range write and read
    tick(); idle(); m1_op(0, 1, 100000, 4'hF, 32'hFFFFFFFF);
    #3 chk("oor_wr_cs", 0, mcs[0], 0);
    chk("oor_wr_wait", 0, wait1[0], 0);
    tick(); idle(); m1_op(1, 0, 100000, 4'hF, 0);
    #3 chk("oor_rd_cs", 0, mcs[0], 0);
    chk("oor_rd_wait", 0, wait1[0], 0);
    tick(); idle();
    #3 chk("oor_rdv", 0, rdv1[0], 1);
    chk("oor_data", 0, rdd1[0], 32'h0);

    // byte lanes
    tick(); idle(); m0_op(0, 1, 7, 4'hF, 32'hAABBCCDD);
    tick(); idle(); m0_op(0, 1, 7, 4'b0010, 32'h00001100);
    tick(); idle(); m0_op(1, 0, 7, 4'hF, 0);
    tick(); idle();
    #3 chk("be_rdv", 0, rdv0[0], 1);
    chk("be_data", 0, rdd0[0], 32'hAABB11DD);

    // read+write together is a write
    tick(); idle(); m0_op(1, 1, 8, 4'hF, 32'h5555);
    #3 chk("rw_we", 0, mwe[0], 1);
    tick(); idle();
    #3 chk("rw_rdv", 0, rdv0[0], 0);
    tick(); idle(); m0_op(1, 0, 8, 4'hF, 0);
    tick(); idle();
    #3 chk("rw_data", 0, rdd0[0], 32'h5555);

    // reset while a read is in flight
    tick(); idle(); m0_op(1, 0, 5, 4'hF, 0);
    tick(); idle(); reset_n = 0;
    #3 chk("mr_rdv_now", 0, rdv0[0], 0);
    chk("mr_rdv_now", 1, rdv0[1], 0);
    tick();
    tick(); reset_n = 1;
    tick(); idle();
    #3 chk("mr_rdv_after", 0, rdv0[0], 0);
    tick(); idle(); m0_op(1, 0, 1, 4'hF, 0); m1_op(1, 0, 2, 4'hF, 0);
    #3 chk("mr_tie0", 0, wait0[0], 0);
    chk("mr_tie1", 0, wait1[0], 1);

    // random traffic with occasional reset pulses
    repeat (3000) begin
      tick();
      reset_n = ($urandom_range(0, 299) != 0);
      rand_master(0);
      rand_master(1);
    end

    tick(); reset_n = 1; idle();
    tick(); idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
